// File: rtl/uart_cmd_master_pkg.sv
// Shared definitions for the UART command link initiator.
// Holds the wire-level command/ack bytes, the request opcode and completion
// code encodings, the FSM state type and the packet byte builder.
// No ports (package).
package uart_cmd_master_pkg;

  // Wire-level command bytes (also used by the packet_gen responder).
  localparam logic [7:0] CMD_RD = 8'h52;
  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] CMD_ST = 8'h53;
  localparam logic [7:0] ACK    = 8'h06;

  // Request opcodes.
  localparam logic [1:0] OP_RD  = 2'd0;
  localparam logic [1:0] OP_WR  = 2'd1;
  localparam logic [1:0] OP_ST  = 2'd2;
  localparam logic [1:0] OP_ILL = 2'd3;

  // Completion codes.
  localparam logic [1:0] ERR_OK  = 2'd0;
  localparam logic [1:0] ERR_TMO = 2'd1;
  localparam logic [1:0] ERR_RX  = 2'd2;
  localparam logic [1:0] ERR_BAD = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEND   = 3'd1,
    ST_TXWAIT = 3'd2,
    ST_RECV   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Index of the final request byte for an opcode (length - 1).
  function automatic logic [1:0] last_idx(input logic [1:0] op);
    logic [1:0] r;
    r = 2'd0;
    case (op)
      OP_RD:   r = 2'd2;
      OP_WR:   r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  // Byte 'idx' of the request packet, MSB-first address.
  function automatic logic [7:0] pkt_byte(input logic [1:0]  op,
                                          input logic [1:0]  idx,
                                          input logic [15:0] addr,
                                          input logic [7:0]  wdata);
    logic [7:0] b;
    b = 8'h00;
    case (op)
      OP_RD: begin
        case (idx)
          2'd0:    b = CMD_RD;
          2'd1:    b = addr[15:8];
          2'd2:    b = addr[7:0];
          default: b = 8'h00;
        endcase
      end
      OP_WR: begin
        case (idx)
          2'd0:    b = CMD_WR;
          2'd1:    b = addr[15:8];
          2'd2:    b = addr[7:0];
          default: b = wdata;
        endcase
      end
      OP_ST:   b = CMD_ST;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_cmd_master_cmd_timeout.sv
// cmd_timeout: 31-bit saturating idle counter for the response wait.
// Ports:
//   clk     in  clock
//   rst     in  asynchronous active-low reset
//   clr     in  synchronous clear to zero (wins over en)
//   en      in  count one per cycle
//   expired out high while the count equals LIMIT
module cmd_timeout #(
  parameter logic [30:0] LIMIT = 31'h6000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [30:0] count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en && (count_q != '1)) begin
      count_q <= count_q + 31'd1;
    end
  end

  assign expired = (count_q == LIMIT);

endmodule

// File: rtl/uart_cmd_master.sv
// uart_cmd_master: host-side command initiator for the UART command link.
// Takes one read/write/status request, sends it as a command packet through
// the byte UART, waits for the single response byte and reports the result.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   req_op/req_addr/req_wdata request contents
//   rsp_valid/rsp_data/rsp_err completion pulse, data and code (held)
//   busy                     high whenever not IDLE
//   tx_byte/transmit         byte and start pulse towards the UART
//   is_transmitting          UART transmitter busy
//   rx_byte/received/recv_error response byte path from the UART
//   dbg_state                current FSM state for observation
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; req_ready drops on the next cycle and returns
// one cycle after the rsp_valid pulse. rsp_valid is a single-cycle pulse
// with no back-pressure.
module uart_cmd_master
  import uart_cmd_master_pkg::*;
#(
  parameter int unsigned DATAP        = 8,
  parameter int unsigned ADDRP        = 16,
  parameter logic [30:0] EXPIRE_AFTER = 31'h6000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [ADDRP-1:0] req_addr,
  input  logic [DATAP-1:0] req_wdata,
  output logic             rsp_valid,
  output logic [DATAP-1:0] rsp_data,
  output logic [1:0]       rsp_err,
  output logic             busy,
  output logic [DATAP-1:0] tx_byte,
  output logic             transmit,
  input  logic             is_transmitting,
  input  logic [DATAP-1:0] rx_byte,
  input  logic             received,
  input  logic             recv_error,
  output logic [2:0]       dbg_state
);

  state_e           state_q;
  logic [1:0]       op_q;
  logic [ADDRP-1:0] addr_q;
  logic [DATAP-1:0] wdata_q;
  logic [1:0]       idx_q;
  logic             first_q;
  logic             req_ready_q;
  logic             busy_q;
  logic             rsp_valid_q;
  logic [DATAP-1:0] rsp_data_q;
  logic [1:0]       rsp_err_q;
  logic [DATAP-1:0] tx_byte_q;
  logic             transmit_q;

  logic [15:0]      req_addr16;
  logic [15:0]      addr16;
  logic [1:0]       idx_nxt;
  logic             expired;

  // Addresses narrower than 16 bits are zero-extended on the wire.
  assign req_addr16 = 16'(req_addr);
  assign addr16     = 16'(addr_q);
  assign idx_nxt    = idx_q + 2'd1;

  // The counter is held at zero outside RECV so it restarts on each entry.
  cmd_timeout #(
    .LIMIT (EXPIRE_AFTER)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_q != ST_RECV),
    .en      (state_q == ST_RECV),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_RD;
      addr_q      <= '0;
      wdata_q     <= '0;
      idx_q       <= 2'd0;
      first_q     <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= ERR_OK;
      tx_byte_q   <= '0;
      transmit_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            op_q        <= req_op;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            idx_q       <= 2'd0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (req_op == OP_ILL) begin
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= '0;
              rsp_err_q   <= ERR_BAD;
              state_q     <= ST_DONE;
            end else begin
              // Byte 0 goes out straight from the accept edge.
              tx_byte_q  <= DATAP'(pkt_byte(req_op, 2'd0, req_addr16, 8'(req_wdata)));
              transmit_q <= 1'b1;
              state_q    <= ST_SEND;
            end
          end
        end

        ST_SEND: begin
          transmit_q <= 1'b0;
          first_q    <= 1'b1;
          state_q    <= ST_TXWAIT;
        end

        ST_TXWAIT: begin
          // The UART raises is_transmitting a cycle late, so the first
          // TXWAIT cycle would see a stale low.
          if (first_q) begin
            first_q <= 1'b0;
          end else if (!is_transmitting) begin
            if (idx_q != last_idx(op_q)) begin
              idx_q      <= idx_nxt;
              tx_byte_q  <= DATAP'(pkt_byte(op_q, idx_nxt, addr16, 8'(wdata_q)));
              transmit_q <= 1'b1;
              state_q    <= ST_SEND;
            end else begin
              state_q <= ST_RECV;
            end
          end
        end

        ST_RECV: begin
          // recv_error outranks a coincident received.
          if (recv_error) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= '0;
            rsp_err_q   <= ERR_RX;
            state_q     <= ST_DONE;
          end else if (received) begin
            rsp_valid_q <= 1'b1;
            if (op_q == OP_WR) begin
              rsp_data_q <= '0;
              rsp_err_q  <= (rx_byte == DATAP'(ACK)) ? ERR_OK : ERR_BAD;
            end else begin
              rsp_data_q <= rx_byte;
              rsp_err_q  <= ERR_OK;
            end
            state_q <= ST_DONE;
          end else if (expired) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= '0;
            rsp_err_q   <= ERR_TMO;
            state_q     <= ST_DONE;
          end
        end

        ST_DONE: begin
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end

        default: begin
          state_q     <= ST_IDLE;
          transmit_q  <= 1'b0;
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign tx_byte   = tx_byte_q;
  assign transmit  = transmit_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_cmd_master.sv
module tb_uart_cmd_master;

  localparam int EXP = 16;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_err;
  logic        busy;
  logic [7:0]  tx_byte;
  logic        transmit;
  logic        is_transmitting;
  logic [7:0]  rx_byte;
  logic        received;
  logic        recv_error;
  logic [2:0]  dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_cmd_master #(
    .DATAP        (8),
    .ADDRP        (16),
    .EXPIRE_AFTER (31'(EXP))
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_op          (req_op),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .rsp_valid       (rsp_valid),
    .rsp_data        (rsp_data),
    .rsp_err         (rsp_err),
    .busy            (busy),
    .tx_byte         (tx_byte),
    .transmit        (transmit),
    .is_transmitting (is_transmitting),
    .rx_byte         (rx_byte),
    .received        (received),
    .recv_error      (recv_error),
    .dbg_state       (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];      // expected transmitted bytes
  logic [9:0] exp_rsp_q[$];  // expected {err, data}
  int checks = 0;
  int errors = 0;
  int tx_seen = 0;
  int tx_cyc = 0;
  int rsp_cyc = 0;
  logic [7:0] last_exp_data = 8'h00;
  int busy_len = 3;
  logic uart_active = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s got %0h expected none (t=%0t)", name, act, $time);
  endtask

  // Transmit and response monitor, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (transmit) begin
          tx_seen++;
          tx_cyc = cyc;
          if (exp_q.size() == 0) flag("tx_unexpected", 32'(tx_byte));
          else check("tx_byte", 32'(tx_byte), 32'(exp_q.pop_front()));
        end
        if (rsp_valid) begin
          rsp_cyc = cyc;
          if (exp_rsp_q.size() == 0) begin
            flag("rsp_unexpected", {22'd0, rsp_err, rsp_data});
          end else begin
            logic [9:0] e;
            e = exp_rsp_q.pop_front();
            last_exp_data = e[7:0];
            check("rsp_data", 32'(rsp_data), 32'(e[7:0]));
            check("rsp_err", 32'(rsp_err), 32'(e[9:8]));
          end
        end
      end
    end
  end

  // Simple UART transmitter model: busy for busy_len cycles after a start.
  initial begin
    is_transmitting = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && transmit && busy_len > 0) begin
        uart_active = 1'b1;
        @(posedge clk);
        #1 is_transmitting = 1'b1;
        repeat (busy_len) @(posedge clk);
        #1 is_transmitting = 1'b0;
        uart_active = 1'b0;
      end
    end
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  function automatic void push_tx(input logic [1:0] op, input logic [15:0] a, input logic [7:0] wd);
    case (op)
      2'd0: begin exp_q.push_back(8'h52); exp_q.push_back(a[15:8]); exp_q.push_back(a[7:0]); end
      2'd1: begin exp_q.push_back(8'h57); exp_q.push_back(a[15:8]); exp_q.push_back(a[7:0]);
                  exp_q.push_back(wd); end
      2'd2: exp_q.push_back(8'h53);
      default: ;
    endcase
  endfunction

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!req_ready && n < 200) begin @(posedge clk); #2; n++; end
    if (!req_ready) flag(name, 32'(n));
  endtask

  task automatic wait_rsp_drained(input string name);
    int n;
    n = 0;
    while (exp_rsp_q.size() != 0 && n < 200) begin @(posedge clk); #2; n++; end
    if (exp_rsp_q.size() != 0) flag(name, 32'(exp_rsp_q.size()));
  endtask

  task automatic drive_req(input logic [1:0] op, input logic [15:0] a, input logic [7:0] wd);
    @(negedge clk);
    req_op = op; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // mode 0: normal reply, 1: received+recv_error together, 2: no reply
  task automatic run_req(input logic [1:0] op, input logic [15:0] a, input logic [7:0] wd,
                         input logic [7:0] rx, input int mode);
    logic [9:0] e;
    int n;
    push_tx(op, a, wd);
    if (op == 2'd3)               e = {2'd3, 8'h00};
    else if (mode == 1)           e = {2'd2, 8'h00};
    else if (mode == 2)           e = {2'd1, 8'h00};
    else if (op == 2'd1)          e = (rx == 8'h06) ? {2'd0, 8'h00} : {2'd3, 8'h00};
    else                          e = {2'd0, rx};
    exp_rsp_q.push_back(e);
    wait_ready("req_ready_wait");
    drive_req(op, a, wd);
    if (op == 2'd3) begin
      @(negedge clk);
      check("illegal_rsp_next_cycle", 32'(rsp_valid), 32'd1);
      check("illegal_no_transmit", 32'(transmit), 32'd0);
    end else if (mode != 2) begin
      n = 0;
      while ((exp_q.size() != 0 || uart_active) && n < 300) begin @(posedge clk); #2; n++; end
      if (exp_q.size() != 0) flag("tx_bytes_missing", 32'(exp_q.size()));
      repeat (3) @(posedge clk);
      @(negedge clk);
      rx_byte = rx; received = 1'b1; recv_error = (mode == 1);
      @(posedge clk);
      @(negedge clk);
      received = 1'b0; recv_error = 1'b0;
      check("rsp_valid_at_M1", 32'(rsp_valid), 32'd1);
      check("ready_low_at_M1", 32'(req_ready), 32'd0);
      @(negedge clk);
      check("ready_high_at_M2", 32'(req_ready), 32'd1);
    end
    wait_rsp_drained("rsp_wait");
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  op;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rx;
    int          mode;
  } vec_t;

  vec_t vecs[6];

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_addr = '0; req_wdata = '0;
    rx_byte = '0; received = 1'b0; recv_error = 1'b0;

    vecs[0] = '{2'd1, 16'h0123, 8'hA5, 8'h06, 0};  // write, ACK
    vecs[1] = '{2'd0, 16'h03FF, 8'h00, 8'h3C, 0};  // read
    vecs[2] = '{2'd1, 16'h0456, 8'h11, 8'h15, 0};  // write, NAK -> err 3
    vecs[3] = '{2'd0, 16'h0010, 8'h00, 8'h99, 1};  // read, error+received -> err 2
    vecs[4] = '{2'd2, 16'h0000, 8'h00, 8'h81, 0};  // status
    vecs[5] = '{2'd3, 16'h1234, 8'h56, 8'h00, 0};  // illegal

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_transmit", 32'(transmit), 32'd0);
    check("rst_tx_byte", 32'(tx_byte), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;

    for (int i = 0; i < 6; i++) run_req(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].rx, vecs[i].mode);

    // Stray received while idle must be ignored.
    @(negedge clk);
    rx_byte = 8'h77; received = 1'b1;
    @(negedge clk);
    received = 1'b0;
    repeat (4) @(negedge clk);
    check("stray_busy", 32'(busy), 32'd0);
    check("stray_ready", 32'(req_ready), 32'd1);
    check("stray_data_held", 32'(rsp_data), 32'(last_exp_data));

    // Status with no reply: timeout. Last transmit at edge p, TXWAIT ignores
    // one cycle, RECV entered at p+3, expiry EXP+1 cycles later.
    busy_len = 0;
    run_req(2'd2, 16'h0000, 8'h00, 8'h00, 2);
    check("timeout_latency", 32'(rsp_cyc - tx_cyc), 32'(EXP + 4));
    busy_len = 3;

    // Random reads and writes.
    for (int i = 0; i < 4; i++) begin
      logic [1:0] op;
      logic [7:0] rx;
      op = 2'($urandom_range(0, 1));
      rx = 8'($urandom_range(0, 255));
      if (op == 2'd1 && $urandom_range(0, 1) == 1) rx = 8'h06;
      run_req(op, 16'($urandom_range(0, 65535)), 8'($urandom_range(0, 255)), rx, 0);
    end

    // Leave a nonzero rsp_data so the reset check below has teeth.
    run_req(2'd0, 16'h2222, 8'h00, 8'h5A, 0);

    // Reset during byte 2 of a write.
    begin
      int base;
      int n;
      base = tx_seen;
      push_tx(2'd1, 16'hABCD, 8'h5A);
      wait_ready("req_ready_wait_rst");
      drive_req(2'd1, 16'hABCD, 8'h5A);
      n = 0;
      do begin @(negedge clk); #1; n++; end while (tx_seen < base + 2 && n < 200);
      if (tx_seen < base + 2) flag("rst_byte2_wait", 32'(tx_seen - base));
      rst = 1'b0;
      #1;
      check("abort_transmit", 32'(transmit), 32'd0);
      check("abort_req_ready", 32'(req_ready), 32'd1);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
      check("abort_tx_byte", 32'(tx_byte), 32'd0);
      check("abort_rsp_data", 32'(rsp_data), 32'd0);
      check("abort_rsp_err", 32'(rsp_err), 32'd0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (10) @(posedge clk);
      #2;
    end
    run_req(2'd0, 16'h0042, 8'h00, 8'hC3, 0);

    repeat (5) @(posedge clk);
    if (exp_q.size() != 0) flag("tx_left_over", 32'(exp_q.size()));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
